// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung adder/subtractor with valid/ready handshake on every stage.
// PIPE selects how many of the p/g, up-sweep and output register cuts are populated.
module bk_adder_pipe #(
   parameter int WIDTH = 16,
   parameter int PIPE  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int LOG = $clog2(WIDTH);
   localparam int UPI = (PIPE >= 2) ? PIPE - 2 : 0;

   typedef struct packed {
      logic [WIDTH-1:0] pp;
      logic [WIDTH-1:0] gg;
   } pg_t;

   // Up-sweep: node i becomes the group (P,G) of the aligned block ending at i.
   function automatic pg_t up_sweep(input pg_t x);
      pg_t y;
      y = x;
      for (int l = 0; l < LOG; l++) begin
         for (int i = (2 << l) - 1; i < WIDTH; i += (2 << l)) begin
            y.gg[i] = y.gg[i] | (y.pp[i] & y.gg[i - (1 << l)]);
            y.pp[i] = y.pp[i] & y.pp[i - (1 << l)];
         end
      end
      return y;
   endfunction

   // Down-sweep: fill in the remaining prefixes from already complete ones.
   function automatic pg_t down_sweep(input pg_t x);
      pg_t y;
      y = x;
      for (int l = LOG - 2; l >= 0; l--) begin
         for (int i = (2 << l) + (1 << l) - 1; i < WIDTH; i += (2 << l)) begin
            y.gg[i] = y.gg[i] | (y.pp[i] & y.gg[i - (1 << l)]);
            y.pp[i] = y.pp[i] & y.pp[i - (1 << l)];
         end
      end
      return y;
   endfunction

   logic [PIPE-1:0] v_q, v_d, ld, src_v;
   logic [PIPE:0]   rdy;

   always_comb begin
      rdy       = '0;
      rdy[PIPE] = out_ready;
      for (int k = PIPE - 1; k >= 0; k--) begin
         rdy[k] = ~v_q[k] | rdy[k + 1];
      end
      src_v    = '0;
      src_v[0] = in_valid;
      for (int k = 1; k < PIPE; k++) begin
         src_v[k] = v_q[k - 1];
      end
      v_d = v_q;
      ld  = '0;
      for (int k = 0; k < PIPE; k++) begin
         if (rdy[k]) v_d[k] = src_v[k];
         ld[k] = rdy[k] & src_v[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) v_q <= '0;
      else        v_q <= v_d;
   end

   assign in_ready  = rdy[0];
   assign out_valid = v_q[PIPE-1];

   logic [WIDTH-1:0] b_eff, p_a, g_a;
   logic             c0_a;

   always_comb begin
      b_eff = sub ? ~b : b;
      c0_a  = sub ? ~cin : cin;
      p_a   = a ^ b_eff;
      g_a   = a & b_eff;
   end

   pg_t  pg_b, up_b, up_c, pre_c;
   logic c0_b, c0_c;
   logic [WIDTH-1:0] p_c;

   generate
      if (PIPE == 3) begin : g_pg_reg
         pg_t  pg1_q, pg1_d;
         logic c01_q, c01_d;
         always_comb begin
            pg1_d = pg1_q;
            c01_d = c01_q;
            if (ld[0]) begin
               pg1_d = {p_a, g_a};
               c01_d = c0_a;
            end
         end
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pg1_q <= '0;
               c01_q <= 1'b0;
            end else begin
               pg1_q <= pg1_d;
               c01_q <= c01_d;
            end
         end
         assign pg_b = pg1_q;
         assign c0_b = c01_q;
      end else begin : g_pg_comb
         assign pg_b = {p_a, g_a};
         assign c0_b = c0_a;
      end
   endgenerate

   assign up_b = up_sweep(pg_b);

   generate
      if (PIPE >= 2) begin : g_up_reg
         pg_t              up2_q, up2_d;
         logic [WIDTH-1:0] p2_q, p2_d;
         logic             c02_q, c02_d;
         always_comb begin
            up2_d = up2_q;
            p2_d  = p2_q;
            c02_d = c02_q;
            if (ld[UPI]) begin
               up2_d = up_b;
               p2_d  = pg_b.pp;
               c02_d = c0_b;
            end
         end
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               up2_q <= '0;
               p2_q  <= '0;
               c02_q <= 1'b0;
            end else begin
               up2_q <= up2_d;
               p2_q  <= p2_d;
               c02_q <= c02_d;
            end
         end
         assign up_c = up2_q;
         assign p_c  = p2_q;
         assign c0_c = c02_q;
      end else begin : g_up_comb
         assign up_c = up_b;
         assign p_c  = pg_b.pp;
         assign c0_c = c0_b;
      end
   endgenerate

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_c, sum_q, sum_d;
   logic             cout_c, ovf_c, cout_q, cout_d, ovf_q, ovf_d;

   // Carry-in is folded in once per bit against the full prefix (P,G)[i:0].
   always_comb begin
      pre_c  = down_sweep(up_c);
      carry  = {pre_c.gg | (pre_c.pp & {WIDTH{c0_c}}), c0_c};
      sum_c  = p_c ^ carry[WIDTH-1:0];
      cout_c = carry[WIDTH];
      ovf_c  = carry[WIDTH] ^ carry[WIDTH-1];
   end

   always_comb begin
      sum_d  = sum_q;
      cout_d = cout_q;
      ovf_d  = ovf_q;
      if (ld[PIPE-1]) begin
         sum_d  = sum_c;
         cout_d = cout_c;
         ovf_d  = ovf_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_bk_adder_pipe.sv
// Bench for bk_adder_pipe: directed table, back-pressure and reset sequences,
// then a randomized handshake sweep scored against an arithmetic reference model.
module tb_bk_adder_pipe;

   localparam int WIDTH = 16;
   localparam int PIPE  = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             cin = 1'b0;
   logic             sub = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   bk_adder_pipe #(.WIDTH(WIDTH), .PIPE(PIPE)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] s;
      logic             co;
      logic             ov;
   } res_t;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             cin;
      logic             sub;
      logic [WIDTH-1:0] s;
      logic             co;
      logic             ov;
   } vec_t;

   res_t exp_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   n_out = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Reference: exact integer a+b+cin or a-b-cin in WIDTH+2 bits.
   function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic ci, input logic sb);
      logic [WIDTH+1:0] ux, uy, uc, ur, sx, sy, sr, sr_fit;
      res_t r;
      ux = {2'b00, x};
      uy = {2'b00, y};
      uc = {{(WIDTH+1){1'b0}}, ci};
      sx = {{2{x[WIDTH-1]}}, x};
      sy = {{2{y[WIDTH-1]}}, y};
      if (!sb) begin
         ur   = ux + uy + uc;
         sr   = sx + sy + uc;
         r.co = ur[WIDTH];
      end else begin
         ur   = ux - uy - uc;
         sr   = sx - sy - uc;
         r.co = ~ur[WIDTH+1];
      end
      r.s    = ur[WIDTH-1:0];
      sr_fit = {{2{sr[WIDTH-1]}}, sr[WIDTH-1:0]};
      r.ov   = (sr_fit != sr);
      return r;
   endfunction

   task automatic step(input logic iv, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                       input logic ic, input logic is, input logic ordy, output logic acc);
      @(negedge clk);
      in_valid  = iv;
      a         = ia;
      b         = ib;
      cin       = ic;
      sub       = is;
      out_ready = ordy;
      #1;
      acc = in_valid && in_ready;
      if (acc) exp_q.push_back(model(ia, ib, ic, is));
   endtask

   // Output monitor: checks hold-stability under back-pressure and result order.
   logic held = 1'b0;
   res_t held_r;
   res_t mon_e;
   always begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
         held = 1'b0;
      end else if (out_valid) begin
         if (held) begin
            check("hold_sum", 64'(sum), 64'(held_r.s));
            check("hold_cout", 64'(cout), 64'(held_r.co));
            check("hold_ovf", 64'(ovf), 64'(held_r.ov));
         end
         if (out_ready) begin
            check("out_has_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check("res_sum", 64'(sum), 64'(mon_e.s));
               check("res_cout", 64'(cout), 64'(mon_e.co));
               check("res_ovf", 64'(ovf), 64'(mon_e.ov));
            end
            n_out++;
            held = 1'b0;
         end else begin
            held   = 1'b1;
            held_r = '{s: sum, co: cout, ov: ovf};
         end
      end else begin
         held = 1'b0;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish by 1000000 ns, want finish");
      $fatal(1);
   end

   vec_t             tbl[10];
   logic [WIDTH-1:0] bp_a[3];
   logic [WIDTH-1:0] bp_b[3];
   logic             bp_s[3];
   logic             acc;
   int               lat;
   int               idx;
   logic             pend;
   logic             ordy;
   res_t             r;

   initial begin
      tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      tbl[2] = '{16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0};
      tbl[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      tbl[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
      tbl[6] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
      tbl[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
      tbl[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      tbl[9] = '{16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
      bp_a = '{16'h1111, 16'h0005, 16'h7FFF};
      bp_b = '{16'h2222, 16'h0007, 16'h0001};
      bp_s = '{1'b0, 1'b1, 1'b0};

      // Reset state
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_cout", 64'(cout), 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      rst_n = 1'b1;

      // Directed table with latency check
      for (int i = 0; i < 10; i++) begin
         step(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 1'b1, acc);
         check("tbl_accept", 64'(acc), 64'd1);
         lat = 0;
         for (int k = 1; k <= 20 && lat == 0; k++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
            if (out_valid) lat = k;
         end
         check("tbl_latency", 64'(lat), 64'(PIPE));
         check("tbl_sum", 64'(sum), 64'(tbl[i].s));
         check("tbl_cout", 64'(cout), 64'(tbl[i].co));
         check("tbl_ovf", 64'(ovf), 64'(tbl[i].ov));
         $display("tbl %0d: a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b lat=%0d",
                  i, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, sum, cout, ovf, lat);
      end

      // Sustained throughput
      for (int k = 0; k < 32; k++) begin
         step(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b1, acc);
         check("tp_accept", 64'(acc), 64'd1);
         if (k >= PIPE) check("tp_out_valid", 64'(out_valid), 64'd1);
      end
      for (int k = 0; k < 8; k++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);

      // Back-pressure: out_ready low for 4 cycles, then release
      idx = 0;
      for (int c = 0; c < 4; c++) begin
         pend = (idx < 3);
         step(pend, bp_a[pend ? idx : 0], bp_b[pend ? idx : 0], 1'b0,
              bp_s[pend ? idx : 0], 1'b0, acc);
         check("bp_in_ready", 64'(acc), 64'(idx < PIPE));
         if (acc) idx++;
         if (c == 3) check("bp_out_valid", 64'(out_valid), 64'd1);
      end
      for (int c = 0; c < 3; c++) begin
         pend = (idx < 3);
         step(pend, bp_a[pend ? idx : 0], bp_b[pend ? idx : 0], 1'b0,
              bp_s[pend ? idx : 0], 1'b1, acc);
         if (pend && c == 0) check("bp_shift_accept", 64'(acc), 64'd1);
         if (acc) idx++;
         r = model(bp_a[c], bp_b[c], 1'b0, bp_s[c]);
         check("bp_drain_valid", 64'(out_valid), 64'd1);
         check("bp_order_sum", 64'(sum), 64'(r.s));
         $display("bp drain %0d: out_valid=%b sum=%h want %h", c, out_valid, sum, r.s);
      end
      for (int k = 0; k < 6; k++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      check("bp_drained", 64'(exp_q.size()), 64'd0);

      // Reset with transactions in flight
      step(1'b1, 16'h1234, 16'h0101, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 16'h4321, 16'h0202, 1'b0, 1'b0, 1'b0, acc);
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_in_ready", 64'(in_ready), 64'd1);
      check("mid_rst_sum", 64'(sum), 64'd0);
      check("mid_rst_cout", 64'(cout), 64'd0);
      check("mid_rst_ovf", 64'(ovf), 64'd0);
      exp_q.delete();
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
         check("post_rst_no_out", 64'(out_valid), 64'd0);
      end
      $display("mid-flight reset: out_valid=%b after release", out_valid);

      // First transfer on the first edge after release
      rst_n = 1'b0;
      exp_q.delete();
      step(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, acc);
      rst_n = 1'b1;
      check("first_accept", 64'(acc), 64'd1);
      lat = 0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
         if (out_valid) lat = k;
      end
      check("first_latency", 64'(lat), 64'(PIPE));
      check("first_sum", 64'(sum), 64'h0100);

      // Random sweep with random valid/ready
      for (int k = 0; k < 4000; k++) begin
         ordy = ((k / 500) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         step($urandom_range(0, 3) != 0, WIDTH'($urandom), WIDTH'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ordy, acc);
      end
      for (int k = 0; k < 20; k++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      check("final_drained", 64'(exp_q.size()), 64'd0);
      $display("random sweep: %0d results delivered in total", n_out);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/bk_adder_pipe.md
BK_ADDER_PIPE -- requirements
Module: bk_adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; legal values are powers of two, 4..64.
REQ-002 SHALL have parameter PIPE, default 2, register stages on the data path; legal values are 1, 2 or 3.
REQ-003 SHALL have port clk, input, 1 bit: sole clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: an operand set is offered this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the operand set this cycle.
REQ-007 SHALL have port a, input, WIDTH bits: operand A.
REQ-008 SHALL have port b, input, WIDTH bits: operand B.
REQ-009 SHALL have port cin, input, 1 bit: carry-in in add mode, borrow-in in subtract mode.
REQ-010 SHALL have port sub, input, 1 bit: 0 = add, 1 = subtract.
REQ-011 SHALL have port out_valid, output, 1 bit: the result is presented.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream consumes the result this cycle.
REQ-013 SHALL have port sum, output, WIDTH bits: result.
REQ-014 SHALL have port cout, output, 1 bit: carry-out in add mode, NOT-borrow in subtract mode.
REQ-015 SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-016 Transfer rules: a transfer in occurs when in_valid and in_ready are both high; a transfer out occurs when out_valid and out_ready are both high.
REQ-017 Operand conditioning:
- effective B = sub ? ~b : b
- effective carry-in c0 = sub ? ~cin : cin
REQ-018 Carry tree:
- bitwise p = a ^ Beff and g = a & Beff
- Brent-Kung prefix with log2(WIDTH) up-sweep levels, then down-sweep
- carry[i+1] = G[i:0] | (P[i:0] & c0) for every bit; the carry-in enters at the prefix root, not as a ripple.
REQ-019 Outputs:
- sum[i] = p[i] ^ carry[i]
- cout = carry[WIDTH]
- ovf = carry[WIDTH] ^ carry[WIDTH-1]
REQ-020 Register placement:
- PIPE=1: output register only.
- PIPE=2: adds a register after the up-sweep (level group P/G plus p, g, c0).
- PIPE=3: also adds a register after p/g generation.
REQ-021 Latency: a transfer in at edge N SHALL produce out_valid with the matching result after edge N+PIPE-1 when there is no back-pressure, i.e. in the cycle following edge N+PIPE-1.
REQ-022 Each stage SHALL have its own valid bit. A stage loads when it is empty or when its content advances in the same cycle; otherwise it holds its data and valid unchanged.
REQ-023 in_ready SHALL equal !v[0] | ready_into_stage1, with the last stage's ready equal to out_ready. Bubbles SHALL collapse, and a combinational ready chain is permitted.
REQ-024 Throughput: one transfer per cycle sustained while out_ready stays high.
REQ-025 Full pipeline with out_ready low:
- in_ready low
- no stage overwritten
- results delivered in acceptance order with no loss or duplication
REQ-026 A simultaneous transfer in and transfer out on a full pipeline SHALL shift all stages and accept the new operand in the same cycle.
REQ-027 sum, cout and ovf SHALL stay stable while out_valid is high and out_ready is low.
REQ-028 in_valid low SHALL inject a bubble. Data ports are don't-care when in_valid is low.
REQ-029 Width wrap-around: the result is modulo 2^WIDTH, and overflow is reported only via cout and ovf.

Reset
REQ-030 While rst_n is low, all valid bits SHALL be 0, sum = 0, cout = 0, ovf = 0, out_valid = 0 and in_ready = 1, asynchronously.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight results, and none SHALL appear after release.
REQ-032 The first transfer in SHALL be possible in the first clock cycle after rst_n rises.

Verification (WIDTH=16, PIPE=2 unless noted)
REQ-033 Add carry wrap: a=FFFF, b=0001, cin=0, sub=0 -> sum=0000, cout=1, ovf=0; out_valid in the cycle after the second edge following acceptance.
REQ-034 Signed overflow and carry-in: a=7FFF, b=0001, cin=0 -> sum=8000, ovf=1, cout=0; a=1234, b=0000, cin=1 -> sum=1235.
REQ-035 Subtract: a=0005, b=0007, sub=1, cin=0 -> sum=FFFE, cout=0, ovf=0; a=8000, b=0001, sub=1 -> sum=7FFF, ovf=1, cout=1.
REQ-036 Back-pressure: three back-to-back operands with out_ready held low for 4 cycles:
- in_ready falls after the 2nd acceptance
- the outputs hold steady
- after out_ready rises, the three results emerge in order on consecutive cycles
REQ-037 Reset mid-flight: assert rst_n low with 2 transactions in flight -> out_valid=0 immediately; after release, out_valid stays 0 until new input is accepted.
REQ-038 Random sweep for PIPE=1,2,3 and WIDTH=8,16,32, 10^5 transfers with random valid/ready -> every result equals the behavioural a±b±cin model, the ordering is preserved, and latency equals PIPE when there are no stalls.
